arcsin_result_tx: RTL and testbench

Downstream stage of the arcsin unit. Each time arcsin strobes a result, this block captures the 8-bit angle code into a small FIFO. It then serialises each code onto a UART-style 8N1 line for the bench/board host. Results that arrive while the FIFO is full are dropped and counted.

---
 rtl/arcsin_pkg.sv | 26 ++
 rtl/arcsin_sync_fifo.sv | 78 +++++++
 rtl/arcsin_result_tx.sv | 196 +++++++++++++++++++
 tb/tb_arcsin_result_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arcsin_pkg.sv
// Shared types and constants for the arcsin result path.
package arcsin_pkg;

  localparam int ANGLE_W = 8;

  // One start bit, eight data bits, one stop bit.
  localparam int UART_FRAME_BITS = 10;

  // Data bits per frame.
  localparam int UART_DATA_BITS = UART_FRAME_BITS - 2;

  typedef logic [ANGLE_W-1:0] angle_t;

  // Serialiser states:
  //   IDLE  | line high, waiting for a buffered code
  //   START | start bit (line low) for one bit period
  //   DATA  | eight data bits, LSB first
  //   STOP  | stop bit (line high), then next code or IDLE
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/arcsin_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is presented on
// data_o whenever the FIFO is non-empty. A push is refused while full, even
// if a pop happens on the same edge; a pop is ignored while empty.
module arcsin_sync_fifo
  import arcsin_pkg::*;
#(
  parameter int WIDTH = ANGLE_W,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    rd_ptr_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next pointer/occupancy values; pointers wrap naturally (DEPTH is 2^AW).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; left without reset since occupancy guards every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/arcsin_result_tx.sv
// Buffers arcsin result codes in a small FIFO and sends each one as an
// 8N1 serial frame. Codes arriving while the FIFO is full are dropped and
// counted in a saturating counter. All outputs come straight from registers.
module arcsin_result_tx
  import arcsin_pkg::*;
#(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_W     = 8
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [7:0]        DATA_I,
  input  logic              VALID_I,
  output logic              READY_O,
  output logic              TX_O,
  output logic              BUSY_O,
  output logic [DROP_W-1:0] DROP_CNT_O
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // FIFO interface
  angle_t        fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          drop;
  logic          pop;

  // Serialiser state
  tx_state_e     state_q;
  tx_state_e     state_d;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic [2:0]    bit_idx_q;
  logic [2:0]    bit_idx_d;
  angle_t        shift_q;
  angle_t        shift_d;
  logic          tx_q;
  logic          tx_d;
  logic          bit_end;

  // Status registers
  logic              busy_q;
  logic              busy_d;
  logic              ready_q;
  logic              ready_d;
  logic [DROP_W-1:0] drop_q;
  logic [DROP_W-1:0] drop_d;

  // fifo_full decodes the same occupancy register that READY_O is derived
  // from, so push/drop always agree with what the producer sees on READY_O.
  assign push = VALID_I && !fifo_full;
  assign drop = VALID_I && fifo_full;

  arcsin_sync_fifo #(
    .WIDTH (ANGLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK_I),
    .rst_i   (RST_I),
    .push_i  (push),
    .data_i  (DATA_I),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Occupancy after this edge, used to register READY_O and BUSY_O so they
  // line up with the FIFO state rather than lagging it by a cycle.
  assign count_nxt = fifo_count + CW'(push) - CW'(pop);

  assign bit_end = (timer_q == TW'(CLK_DIV - 1));

  // Frame sequencing; tx_d is the line level for the state being entered.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        tx_d    = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = DATA;
          tx_d      = shift_q[0];
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_d = '0;
          if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_d = '0;
          // Chain straight into the next start bit so back-to-back codes
          // leave no idle gap on the line.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Status next-state: busy/ready follow the post-edge state and occupancy.
  always_comb begin
    busy_d  = (state_d != IDLE) || (count_nxt != '0);
    ready_d = (count_nxt != CW'(FIFO_DEPTH));
    drop_d  = drop_q;
    if (drop && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  // Serialiser registers; reset aborts any frame and parks the line high.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  // Status registers.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      drop_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      ready_q <= ready_d;
      drop_q  <= drop_d;
    end
  end

  assign TX_O       = tx_q;
  assign BUSY_O     = busy_q;
  assign READY_O    = ready_q;
  assign DROP_CNT_O = drop_q;

endmodule

// File: tb/tb_arcsin_result_tx.sv
// Bench for arcsin_result_tx. Two instances: a fast one (4 cycles/bit,
// 4-deep FIFO) for timing, overflow and reset, and a slower one (100
// cycles/bit, 8-deep FIFO) for drop-counter saturation. Each line is
// decoded by its own receiver that pops the expected-code queue.
module tb_arcsin_result_tx;

  localparam int DIV_A   = 4;
  localparam int DEPTH_A = 4;
  localparam int DIV_B   = 100;
  localparam int DEPTH_B = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, rst_b = 1'b1;
  logic [7:0] data_a = '0, data_b = '0;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       ready_a, ready_b, tx_a, tx_b, busy_a, busy_b;
  logic [7:0] drop_a, drop_b;

  arcsin_result_tx #(.CLK_DIV(DIV_A), .FIFO_DEPTH(DEPTH_A), .DROP_W(8)) dut_a (
    .CLK_I(clk), .RST_I(rst_a), .DATA_I(data_a), .VALID_I(valid_a),
    .READY_O(ready_a), .TX_O(tx_a), .BUSY_O(busy_a), .DROP_CNT_O(drop_a));

  arcsin_result_tx #(.CLK_DIV(DIV_B), .FIFO_DEPTH(DEPTH_B), .DROP_W(8)) dut_b (
    .CLK_I(clk), .RST_I(rst_b), .DATA_I(data_b), .VALID_I(valid_b),
    .READY_O(ready_b), .TX_O(tx_b), .BUSY_O(busy_b), .DROP_CNT_O(drop_b));

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected line level at position p (cycles) within a frame of code b.
  function automatic logic frame_bit(input logic [7:0] b, input int p, input int div);
    int slot;
    slot = p / div;
    if (slot == 0) return 1'b0;
    if (slot >= 9) return 1'b1;
    return b[3'(slot - 1)];
  endfunction

  // Receiver for instance A
  int         ra_cnt;
  bit         ra_act;
  logic [7:0] ra_byte;
  logic [31:0] ra_exp;
  initial begin
    ra_act = 0; ra_cnt = 0; ra_byte = '0;
    forever begin
      @(negedge clk);
      if (rst_a) begin
        ra_act = 0; ra_cnt = 0;
      end else if (!ra_act) begin
        if (tx_a === 1'b0) begin ra_act = 1; ra_cnt = 0; end
      end else begin
        ra_cnt++;
        if (ra_cnt == DIV_A / 2) check("rxa_start", 32'(tx_a), 0);
        if (ra_cnt >= DIV_A && ra_cnt < 9 * DIV_A && (ra_cnt % DIV_A) == DIV_A / 2)
          ra_byte[3'(ra_cnt / DIV_A - 1)] = tx_a;
        if (ra_cnt == 9 * DIV_A + DIV_A / 2) begin
          check("rxa_stop", 32'(tx_a), 1);
          ra_exp = (q_a.size() > 0) ? {24'h0, q_a.pop_front()} : 32'hDEAD0000;
          check("rxa_byte", {24'h0, ra_byte}, ra_exp);
          ra_act = 0;
        end
      end
    end
  end

  // Receiver for instance B
  int         rb_cnt;
  bit         rb_act;
  logic [7:0] rb_byte;
  logic [31:0] rb_exp;
  initial begin
    rb_act = 0; rb_cnt = 0; rb_byte = '0;
    forever begin
      @(negedge clk);
      if (rst_b) begin
        rb_act = 0; rb_cnt = 0;
      end else if (!rb_act) begin
        if (tx_b === 1'b0) begin rb_act = 1; rb_cnt = 0; end
      end else begin
        rb_cnt++;
        if (rb_cnt >= DIV_B && rb_cnt < 9 * DIV_B && (rb_cnt % DIV_B) == DIV_B / 2)
          rb_byte[3'(rb_cnt / DIV_B - 1)] = tx_b;
        if (rb_cnt == 9 * DIV_B + DIV_B / 2) begin
          check("rxb_stop", 32'(tx_b), 1);
          rb_exp = (q_b.size() > 0) ? {24'h0, q_b.pop_front()} : 32'hDEAD0000;
          check("rxb_byte", {24'h0, rb_byte}, rb_exp);
          rb_act = 0;
        end
      end
    end
  end

  task automatic drive_a(input logic [7:0] b);
    @(posedge clk); #1;
    valid_a = 1'b1; data_a = b; q_a.push_back(b);
  endtask

  // Push one code and check every cycle of the resulting frame.
  task automatic frame_a(input logic [7:0] b, input string tag);
    drive_a(b);
    @(negedge clk); check({tag, "_busy_pre"}, 32'(busy_a), 0);
    @(posedge clk); #1; valid_a = 1'b0;
    for (int j = 0; j < 41; j++) begin
      @(negedge clk);
      check({tag, "_tx"}, 32'(tx_a), (j == 0) ? 32'd1 : 32'(frame_bit(b, j - 1, DIV_A)));
      check({tag, "_busy"}, 32'(busy_a), 1);
    end
    @(negedge clk); check({tag, "_busy_end"}, 32'(busy_a), 0);
  endtask

  task automatic wait_idle_a(input int limit, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy_a && n < limit);
    check(tag, 32'(busy_a), 0);
  endtask

  task automatic wait_idle_b(input int limit, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy_b && n < limit);
    check(tag, 32'(busy_b), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: run time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random inputs
    repeat (4) begin
      @(posedge clk); #1;
      valid_a = 1'($urandom); data_a = 8'($urandom);
      valid_b = 1'($urandom); data_b = 8'($urandom);
      @(negedge clk);
      check("rst_tx_a", 32'(tx_a), 1);
      check("rst_busy_a", 32'(busy_a), 0);
      check("rst_ready_a", 32'(ready_a), 1);
      check("rst_drop_a", 32'(drop_a), 0);
      check("rst_tx_b", 32'(tx_b), 1);
      check("rst_busy_b", 32'(busy_b), 0);
      check("rst_ready_b", 32'(ready_b), 1);
      check("rst_drop_b", 32'(drop_b), 0);
    end
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_tx_a", 32'(tx_a), 1);
      check("idle_busy_a", 32'(busy_a), 0);
    end

    // Single frame
    frame_a(8'hA5, "single");
    repeat (3) @(posedge clk);

    // Back-to-back frames with no idle gap
    drive_a(8'h00);
    @(negedge clk); check("b2b_busy_pre", 32'(busy_a), 0);
    drive_a(8'hFF);
    @(negedge clk);
    check("b2b_tx0", 32'(tx_a), 1);
    check("b2b_busy0", 32'(busy_a), 1);
    @(posedge clk); #1; valid_a = 1'b0;
    for (int j = 1; j <= 80; j++) begin
      @(negedge clk);
      check("b2b_tx", 32'(tx_a),
            (j <= 40) ? 32'(frame_bit(8'h00, j - 1, DIV_A)) : 32'(frame_bit(8'hFF, j - 41, DIV_A)));
      check("b2b_busy", 32'(busy_a), 1);
    end
    @(negedge clk); check("b2b_busy_end", 32'(busy_a), 0);
    repeat (3) @(posedge clk);

    // Overflow: 7 pushes into a 4-deep FIFO while the first frame is sent
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      check("ovf_ready", 32'(ready_a), (i - 1 >= 5) ? 32'd0 : 32'd1);
      check("ovf_drop_mid", 32'(drop_a), (i - 1 > 5) ? 32'(i - 6) : 32'd0);
      valid_a = 1'b1; data_a = 8'(i);
      if (i <= 5) q_a.push_back(8'(i));
    end
    @(posedge clk); #1; valid_a = 1'b0;
    check("ovf_ready_end", 32'(ready_a), 0);
    check("ovf_drop", 32'(drop_a), 2);
    wait_idle_a(400, "ovf_drain");
    check("ovf_q_empty", 32'(q_a.size()), 0);
    check("ovf_ready_back", 32'(ready_a), 1);
    repeat (3) @(posedge clk);

    // Reset during data bit 3 of 0x3C with 0x55 still queued
    drive_a(8'h3C);
    drive_a(8'h55);
    @(posedge clk); #1; valid_a = 1'b0;
    for (int j = 1; j <= 18; j++) @(negedge clk);
    check("mrst_tx_pre", 32'(tx_a), 32'(frame_bit(8'h3C, 17, DIV_A)));
    check("mrst_busy_pre", 32'(busy_a), 1);
    #2; rst_a = 1'b1;
    #1;
    check("mrst_tx_now", 32'(tx_a), 1);
    check("mrst_busy_now", 32'(busy_a), 0);
    check("mrst_ready_now", 32'(ready_a), 1);
    check("mrst_drop_now", 32'(drop_a), 0);
    q_a.delete();
    repeat (2) @(posedge clk);
    #1; rst_a = 1'b0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      check("mrst_quiet_tx", 32'(tx_a), 1);
      check("mrst_quiet_busy", 32'(busy_a), 0);
    end
    frame_a(8'h81, "after_rst");
    check("after_rst_q_empty", 32'(q_a.size()), 0);

    // Drop-counter saturation on instance B
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      valid_b = 1'b1; data_b = 8'($urandom); q_b.push_back(data_b);
    end
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (i == 0) check("sat_ready_full", 32'(ready_b), 0);
      if (i == 100) check("sat_drop_100", 32'(drop_b), 100);
      data_b = 8'($urandom);
    end
    @(posedge clk); #1; valid_b = 1'b0;
    check("sat_drop_255", 32'(drop_b), 255);
    check("sat_ready_end", 32'(ready_b), 0);
    wait_idle_b(12000, "sat_drain");
    check("sat_q_empty", 32'(q_b.size()), 0);
    check("sat_drop_hold", 32'(drop_b), 255);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
